// File: rtl/rv32i_types.sv
// Shared RV32I execute-side types: ALU op encoding, opcodes, funct3 codes and
// the issue packet carried across the ID/EX boundary.
package rv32i_types;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLL = 3'd2,
        ALU_SRL = 3'd3,
        ALU_SRA = 3'd4,
        ALU_XOR = 3'd5,
        ALU_OR  = 3'd6,
        ALU_AND = 3'd7
    } alu_op_t;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        alu_op_t     aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic        sel_cmp;
        logic        cmp_unsigned;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
        logic [31:0] pc;
    } issue_pkt_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decode into an issue packet.
// ISSUE_SHAMT_MASK_EN: when defined, shift operand b is clipped to 5 bits.
module alu_issue_decode
    import rv32i_types::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_v_i,
    input  logic [31:0] rs2_v_i,
    output issue_pkt_t  pkt_o
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_ok;
    logic       legal;
    logic       is_shift;

    assign f3       = inst_i[14:12];
    assign f7       = inst_i[31:25];
    // 0100000 is only meaningful for sub and sra
    assign f7_ok    = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == F3_ADD) || (f3 == F3_SR)));
    assign is_shift = (f3 == F3_SLL) || (f3 == F3_SR);

    function automatic alu_op_t f3_to_op(input logic [2:0] fn, input logic alt);
        case (fn)
            F3_ADD:  f3_to_op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  f3_to_op = ALU_SLL;
            F3_SLT:  f3_to_op = ALU_SUB;
            F3_SLTU: f3_to_op = ALU_SUB;
            F3_XOR:  f3_to_op = ALU_XOR;
            F3_SR:   f3_to_op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   f3_to_op = ALU_OR;
            default: f3_to_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        pkt_o              = '0;
        pkt_o.pc           = pc_i;
        pkt_o.rd           = inst_i[11:7];
        legal              = 1'b0;
        case (inst_i[6:0])
            OPC_OP: begin
                legal   = f7_ok;
                pkt_o.aluop = f3_to_op(f3, f7[5]);
                pkt_o.a = rs1_v_i;
                pkt_o.b = rs2_v_i;
`ifdef ISSUE_SHAMT_MASK_EN
                if (is_shift) pkt_o.b[31:5] = '0;
`endif
            end
            OPC_OP_IMM: begin
                pkt_o.a = rs1_v_i;
                if (is_shift) begin
                    legal       = f7_ok;
                    pkt_o.aluop = f3_to_op(f3, f7[5]);
                    pkt_o.b     = {27'b0, inst_i[24:20]};
                end else begin
                    legal       = 1'b1;
                    pkt_o.aluop = f3_to_op(f3, 1'b0);
                    pkt_o.b     = {{20{inst_i[31]}}, inst_i[31:20]};
                end
            end
            OPC_LUI: begin
                legal       = 1'b1;
                pkt_o.aluop = ALU_ADD;
                pkt_o.b     = {inst_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal       = 1'b1;
                pkt_o.aluop = ALU_ADD;
                pkt_o.a     = pc_i;
                pkt_o.b     = {inst_i[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase

        if ((inst_i[6:0] == OPC_OP) || (inst_i[6:0] == OPC_OP_IMM)) begin
            pkt_o.sel_cmp      = (f3 == F3_SLT) || (f3 == F3_SLTU);
            pkt_o.cmp_unsigned = pkt_o.sel_cmp & f3[0];
        end

        if (!legal) begin
            pkt_o.aluop        = ALU_ADD;
            pkt_o.a            = '0;
            pkt_o.b            = '0;
            pkt_o.sel_cmp      = 1'b0;
            pkt_o.cmp_unsigned = 1'b0;
            pkt_o.illegal      = 1'b1;
            pkt_o.we           = 1'b0;
        end else begin
            pkt_o.we = (pkt_o.rd != 5'd0);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ID/EX issue stage: decode plus a main/skid buffer so in_ready is a flop.
// ISSUE_SHAMT_MASK_EN (see alu_issue_decode) controls shift operand masking.
module alu_issue_stage
    import rv32i_types::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_v,
    input  logic [XLEN-1:0] in_rs2_v,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_aluop,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic            out_sel_cmp,
    output logic            out_cmp_unsigned,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    issue_pkt_t dec_pkt;
    issue_pkt_t main_q, main_d, skid_q, skid_d;
    logic       main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic       xfer, retire;

    alu_issue_decode u_decode (
        .inst_i  (in_inst),
        .pc_i    (in_pc),
        .rs1_v_i (in_rs1_v),
        .rs2_v_i (in_rs2_v),
        .pkt_o   (dec_pkt)
    );

    assign in_ready = !skid_v_q;
    assign xfer     = in_valid && !skid_v_q;
    assign retire   = main_v_q && out_ready;

    // skid can only be occupied while in_ready is low, so it never races an input transfer
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (retire || !main_v_q) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (xfer) begin
                main_d   = dec_pkt;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (xfer) begin
            skid_d   = dec_pkt;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    always_comb begin
        assert (!rst_n || (32'(main_v_q) + 32'(skid_v_q) <= SKID_DEPTH));
        assert (!rst_n || !skid_v_q || main_v_q);
    end

    assign out_valid        = main_v_q;
    assign out_aluop        = main_q.aluop;
    assign out_a            = main_q.a;
    assign out_b            = main_q.b;
    assign out_sel_cmp      = main_q.sel_cmp;
    assign out_cmp_unsigned = main_q.cmp_unsigned;
    assign out_rd           = main_q.rd;
    assign out_we           = main_q.we;
    assign out_illegal      = main_q.illegal;
    assign out_pc           = main_q.pc;

endmodule
